score_display: RTL and testbench

//  Reader side of the game state bus: takes the game block's score (timealive) and lives outputs.

---
 rtl/game_pkg.sv | 38 +++
 rtl/bin2bcd16.sv | 67 ++++++
 rtl/score_display.sv | 108 ++++++++++
 tb/tb_score_display.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the game state bus readers: conversion FSM encoding,
// seven-segment decimal table and small helpers for the BCD engine.
package game_pkg;

  localparam int          NUM_DIGITS = 4;
  localparam logic [15:0] MAX_SCORE  = 16'd9999;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Segments {g,f,e,d,c,b,a}, active low; entry [0] is the digit 0.
  localparam logic [9:0][6:0] SEG_LUT = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    s = 7'h7F;
    if (d <= 4'd9) s = SEG_LUT[d];
    return s;
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/bin2bcd16.sv
// Sequential double-dabble converter: 16-bit binary (clamped to 9999) to
// 4-digit packed BCD, one shift per clock, start/busy/done handshake.
//
//   state    | meaning
//   ST_IDLE  | waiting for start
//   ST_LOAD  | capture clamped input, clear BCD shift register
//   ST_SHIFT | 16 cycles of add-3 then shift left
//   ST_DONE  | bcd_out valid for this cycle, back to idle
module bin2bcd16
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        clr_n,
  input  logic        start,
  input  logic [15:0] bin_in,
  output logic        busy,
  output logic        load,
  output logic        done,
  output logic [15:0] bcd_out
);

  logic [1:0]  state;
  logic [15:0] bin_sh;
  logic [15:0] bcd_sh;
  logic [15:0] bcd_adj;
  logic [3:0]  bit_cnt;

  always_comb begin
    bcd_adj = {add3(bcd_sh[15:12]), add3(bcd_sh[11:8]),
               add3(bcd_sh[7:4]),   add3(bcd_sh[3:0])};
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= ST_IDLE;
      bin_sh  <= 16'd0;
      bcd_sh  <= 16'd0;
      bit_cnt <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) state <= ST_LOAD;
        end
        ST_LOAD: begin
          bin_sh  <= (bin_in > MAX_SCORE) ? MAX_SCORE : bin_in;
          bcd_sh  <= 16'd0;
          bit_cnt <= 4'd15;
          state   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          {bcd_sh, bin_sh} <= {bcd_adj[14:0], bin_sh, 1'b0};
          if (bit_cnt == 4'd0) state <= ST_DONE;
          else bit_cnt <= bit_cnt - 4'd1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = (state != ST_IDLE);
  assign load    = (state == ST_LOAD);
  assign done    = (state == ST_DONE);
  assign bcd_out = bcd_sh;

endmodule

// File: rtl/score_display.sv
// Score/lives reader driving a 4-digit multiplexed seven-segment display.
// Define LEAD_ZERO_BLANK_EN to blank leading zeros above the units digit.
module score_display
  import game_pkg::*;
#(
  parameter int SCAN_DIV   = 100000,
  parameter int BLINK_BITS = 26
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [15:0] timealive,
  input  logic [1:0]  lives,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        busy
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [15:0]           last_val;
  logic [15:0]           digits;
  logic [15:0]           bcd;
  logic                  start;
  logic                  eng_busy;
  logic                  eng_load;
  logic                  eng_done;
  logic [SCAN_W-1:0]     scan_cnt;
  logic [1:0]            idx;
  logic [BLINK_BITS-1:0] blink_cnt;
  logic [3:0]            cur_digit;
  logic                  blank;
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;
  logic [3:0]            an_nxt;

  // Changes seen while busy are picked up once the engine is back in idle.
  assign start = !eng_busy && (timealive != last_val);

  bin2bcd16 u_bin2bcd16 (
    .clk     (clk),
    .clr_n   (clr_n),
    .start   (start),
    .bin_in  (timealive),
    .busy    (eng_busy),
    .load    (eng_load),
    .done    (eng_done),
    .bcd_out (bcd)
  );

  assign busy = eng_busy;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      last_val <= 16'd0;
      digits   <= 16'd0;
    end else begin
      if (eng_load) last_val <= timealive;
      if (eng_done) digits   <= bcd;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      scan_cnt  <= '0;
      idx       <= 2'd0;
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
      if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        idx      <= idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    cur_digit = digits[{idx, 2'b00} +: 4];
    blank     = 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
    case (idx)
      2'd3:    blank = (digits[15:12] == 4'd0);
      2'd2:    blank = (digits[15:8] == 8'd0);
      2'd1:    blank = (digits[15:4] == 12'd0);
      default: blank = 1'b0;
    endcase
`endif
    seg_nxt = blank ? 7'h7F : seg_encode(cur_digit);
    dp_nxt  = (idx < lives) ? 1'b0 : 1'b1;
    if ((lives == 2'd0) && !blink_cnt[BLINK_BITS-1]) an_nxt = 4'hF;
    else an_nxt = ~(4'b0001 << idx);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      seg <= 7'h7F;
      dp  <= 1'b1;
      an  <= 4'hF;
    end else begin
      seg <= seg_nxt;
      dp  <= dp_nxt;
      an  <= an_nxt;
    end
  end

endmodule

// File: tb/tb_score_display.sv
// Directed self-checking bench for score_display (SCAN_DIV=4, BLINK_BITS=4).
module tb_score_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'h7F;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic [15:0] timealive = 16'd0;
  logic [1:0]  lives = 2'd3;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  score_display #(.SCAN_DIV(4), .BLINK_BITS(4)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .timealive (timealive),
    .lives     (lives),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic wait_an(input logic [3:0] target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (an === target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Waits for busy to rise, then counts the negedges on which it stays high.
  task automatic count_busy(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (busy === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (busy !== 1'b1) begin
          ok = 1'b1;
          break;
        end
        n++;
        @(negedge clk);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    bit ok;
    clr_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (seg !== SB || an !== 4'hF || dp !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset: seg=%b an=%b dp=%b busy=%b, want seg=1111111 an=1111 dp=1 busy=0",
               seg, an, dp, busy);
    end
    clr_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      n_cmp++;
      if (an !== ~(4'b0001 << ((k - 1) / 4))) begin
        n_err++;
        $display("FAIL scan_seq k=%0d: an=%b want %b", k, an, ~(4'b0001 << ((k - 1) / 4)));
      end
    end
    ok = 1'b1;
  endtask

  task automatic test_convert_1234();
    int n;
    bit ok;
    timealive = 16'd1234;
    @(negedge clk);
    count_busy(n, ok);
    n_cmp++;
    if (!ok || n != 18) begin
      n_err++;
      $display("FAIL busy_len_1234: got %0d cycles (ok=%0d) want 18", n, ok);
    end
    wait_an(4'b1110, ok);
    n_cmp++;
    if (!ok || seg !== S4 || dp !== 1'b0) begin
      n_err++;
      $display("FAIL digit0_1234: seg=%b dp=%b want seg=%b dp=0", seg, dp, S4);
    end
    wait_an(4'b1101, ok);
    n_cmp++;
    if (!ok || seg !== S3) begin
      n_err++;
      $display("FAIL digit1_1234: seg=%b want %b", seg, S3);
    end
    wait_an(4'b1011, ok);
    n_cmp++;
    if (!ok || seg !== S2) begin
      n_err++;
      $display("FAIL digit2_1234: seg=%b want %b", seg, S2);
    end
    wait_an(4'b0111, ok);
    n_cmp++;
    if (!ok || seg !== S1 || dp !== 1'b1) begin
      n_err++;
      $display("FAIL digit3_1234: seg=%b dp=%b want seg=%b dp=1", seg, dp, S1);
    end
  endtask

  task automatic test_clamp();
    int n;
    int hi;
    bit ok;
    timealive = 16'd9999;
    @(negedge clk);
    count_busy(n, ok);
    n_cmp++;
    if (!ok || n != 18) begin
      n_err++;
      $display("FAIL busy_len_9999: got %0d cycles (ok=%0d) want 18", n, ok);
    end
    for (int d = 0; d < 4; d++) begin
      wait_an(~(4'b0001 << d), ok);
      n_cmp++;
      if (!ok || seg !== S9) begin
        n_err++;
        $display("FAIL digit%0d_9999: seg=%b want %b", d, seg, S9);
      end
    end
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) hi++;
    end
    n_cmp++;
    if (hi != 0) begin
      n_err++;
      $display("FAIL no_reconvert: busy high %0d cycles want 0", hi);
    end
    timealive = 16'hFFFF;
    @(negedge clk);
    count_busy(n, ok);
    n_cmp++;
    if (!ok || n != 18) begin
      n_err++;
      $display("FAIL busy_len_ffff: got %0d cycles (ok=%0d) want 18", n, ok);
    end
    wait_an(4'b1110, ok);
    n_cmp++;
    if (!ok || seg !== S9) begin
      n_err++;
      $display("FAIL digit0_ffff: seg=%b want %b", seg, S9);
    end
    wait_an(4'b0111, ok);
    n_cmp++;
    if (!ok || seg !== S9) begin
      n_err++;
      $display("FAIL digit3_ffff: seg=%b want %b", seg, S9);
    end
  endtask

  task automatic test_change_while_busy();
    int n;
    int gap;
    bit ok;
    timealive = 16'd5;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
    timealive = 16'd6;
    for (int i = 0; i < 40; i++) begin
      if (busy !== 1'b1) break;
      @(negedge clk);
    end
    gap = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy === 1'b1) break;
      gap++;
      @(negedge clk);
    end
    n_cmp++;
    if (!ok || gap != 1) begin
      n_err++;
      $display("FAIL reconvert_gap: idle gap %0d cycles (started=%0d) want 1", gap, ok);
    end
    count_busy(n, ok);
    n_cmp++;
    if (!ok || n != 18) begin
      n_err++;
      $display("FAIL busy_len_second: got %0d cycles want 18", n);
    end
    wait_an(4'b1110, ok);
    n_cmp++;
    if (!ok || seg !== S6) begin
      n_err++;
      $display("FAIL digit0_final6: seg=%b want %b", seg, S6);
    end
    wait_an(4'b1101, ok);
    n_cmp++;
`ifdef LEAD_ZERO_BLANK_EN
    if (!ok || seg !== SB) begin
      n_err++;
      $display("FAIL digit1_final6: seg=%b want %b", seg, SB);
    end
`else
    if (!ok || seg !== S0) begin
      n_err++;
      $display("FAIL digit1_final6: seg=%b want %b", seg, S0);
    end
`endif
  endtask

  task automatic test_lives();
    bit ok;
    int run_on;
    int run_off;
    logic [3:0] exp_dp;
    lives = 2'd2;
    exp_dp = 4'b1100;
    for (int d = 0; d < 4; d++) begin
      wait_an(~(4'b0001 << d), ok);
      n_cmp++;
      if (!ok || dp !== exp_dp[d]) begin
        n_err++;
        $display("FAIL dp_lives2_digit%0d: dp=%b want %b", d, dp, exp_dp[d]);
      end
    end
    lives = 2'd0;
    wait_an(4'hF, ok);
    for (int i = 0; i < 40; i++) begin
      if (an !== 4'hF) break;
      @(negedge clk);
    end
    run_on = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (an === 4'hF) break;
      run_on++;
    end
    run_off = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (an !== 4'hF) break;
      run_off++;
    end
    n_cmp++;
    if (!ok || run_on != 8 || run_off != 8) begin
      n_err++;
      $display("FAIL blink: scan run %0d blank run %0d want 8 and 8", run_on, run_off);
    end
    lives = 2'd3;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_shift();
    int n;
    bit ok;
    timealive = 16'd4321;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy === 1'b1) break;
    end
    repeat (5) @(negedge clk);
    clr_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || an !== 4'hF || seg !== SB) begin
      n_err++;
      $display("FAIL mid_reset: busy=%b an=%b seg=%b want busy=0 an=1111 seg=1111111", busy, an, seg);
    end
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || an !== 4'b1110 || seg !== S0) begin
      n_err++;
      $display("FAIL after_reset: busy=%b an=%b seg=%b want busy=1 an=1110 seg=%b",
               busy, an, seg, S0);
    end
    count_busy(n, ok);
    n_cmp++;
    if (!ok || n != 18) begin
      n_err++;
      $display("FAIL busy_len_4321: got %0d cycles want 18", n);
    end
    wait_an(4'b1110, ok);
    n_cmp++;
    if (!ok || seg !== S1) begin
      n_err++;
      $display("FAIL digit0_4321: seg=%b want %b", seg, S1);
    end
    wait_an(4'b0111, ok);
    n_cmp++;
    if (!ok || seg !== S4) begin
      n_err++;
      $display("FAIL digit3_4321: seg=%b want %b", seg, S4);
    end
  endtask

  task automatic test_small_value();
    int n;
    bit ok;
    timealive = 16'd7;
    @(negedge clk);
    count_busy(n, ok);
    wait_an(4'b1110, ok);
    n_cmp++;
    if (!ok || seg !== S7) begin
      n_err++;
      $display("FAIL digit0_7: seg=%b want %b", seg, S7);
    end
    for (int d = 1; d < 4; d++) begin
      wait_an(~(4'b0001 << d), ok);
      n_cmp++;
`ifdef LEAD_ZERO_BLANK_EN
      if (!ok || seg !== SB) begin
        n_err++;
        $display("FAIL digit%0d_7: seg=%b want %b", d, seg, SB);
      end
`else
      if (!ok || seg !== S0) begin
        n_err++;
        $display("FAIL digit%0d_7: seg=%b want %b", d, seg, S0);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_convert_1234();
    test_clamp();
    test_change_while_busy();
    test_lives();
    test_reset_mid_shift();
    test_small_value();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
